uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that sits directly downstream of the UART transmitter: it consumes the 8N1 serial line the transmitter drives, recovers bytes, and presents each one as a single-cycle valid strobe. It also keeps a running 32-bit byte checksum and raises a done flag once the line has gone quiet after traffic. This lets the top level loop transmitter output back into a self-checking receive path in both simulation and hardware.

## Interface

- cycles_per_bit, 3, clock cycles per serial bit; integer >= 3; must match the transmitter.
- idle_bits, 16, number of bit times of continuous high line (after at least one byte) before o_done asserts.

- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- i_serial  input  1  serial line, idle high, 8N1, LSB first; asynchronous to clk.
- o_data  output  8  last accepted byte; holds until next accepted byte.
- o_valid  output  1  one-cycle strobe: o_data newly updated this cycle.
- o_frame_err  output  1  one-cycle strobe: stop bit sampled low; byte discarded.
- o_done  output  1  level: line idle for idle_bits bit times since last byte.
- o_sum  output  32  mod-2^32 sum of all accepted bytes since reset.

## Operation

- Input: 2-flop synchronizer on i_serial; both flops reset to 1. FSM sees only the synchronized line (sync2).
- CPB = cycles_per_bit, H = floor(CPB/2). One down-counter for bit timing, 3-bit bit index, 8-bit shift register.
- States:
  - IDLE: sync2 low -> START, counter = H.
  - START: at counter expiry re-sample; low -> DATA, counter = CPB, index 0; high -> IDLE (false start, no outputs).
  - DATA: at each expiry shift sample in LSB-first, reload CPB; after 8th sample -> STOP.
  - STOP: at expiry sample stop bit. High -> o_data = shifted byte, o_valid = 1, o_sum += byte, -> IDLE. Low -> o_frame_err = 1, o_data/o_sum unchanged, -> BREAK.
  - BREAK: wait for sync2 high, then -> IDLE (no new start detection while low).
- o_done: idle counter counts cycles with state IDLE and sync2 high, only once at least one byte has been accepted since reset; asserts when count reaches idle_bits*CPB and stays high (counter saturates). Cleared in the cycle the FSM leaves IDLE. Frame errors do not count as bytes.
- o_sum wraps silently modulo 2^32; zero-extend the byte before adding.
- o_valid and o_frame_err are never high in the same cycle.

## Timing

- Reset values: o_data 0x00, o_valid 0, o_frame_err 0, o_done 0, o_sum 0, state IDLE, sync flops 1. Reset asserted mid-byte abandons the byte with no strobe; after release the receiver waits for a fresh falling edge (a line still low counts as a start).
- Let E0 = first clk edge capturing i_serial low into sync1. FSM enters START at E0+2. Start re-sample at E0+2+H; data bit k sampled at E0+2+H+(k+1)*CPB; stop bit at E0+2+H+9*CPB. o_valid (or o_frame_err) is high for exactly the one cycle following that edge, together with updated o_data/o_sum.
- Back-to-back frames: a start bit arriving immediately after the stop bit is accepted; FSM is back in IDLE H+1 cycles... before the next frame's edge reaches sync2, so zero idle gap between frames is supported for CPB >= 3.
- Start glitches shorter than H+1 cycles at sync2 produce no output.

## Test plan

- CPB=3, send 0x48 from idle -> exactly one o_valid pulse, one cycle after edge E0+2+1+27 = E0+30; o_data = 0x48, o_sum = 0x00000048, o_frame_err never high.
- Send "Hi" (0x48, 0x69) back-to-back, no idle gap -> two o_valid pulses 30 cycles apart, final o_sum = 0x000000B1, o_data = 0x69.
- 1-cycle low glitch on i_serial while idle -> no o_valid, no o_frame_err, state returns to IDLE, o_sum unchanged.
- Frame 0x55 with stop bit driven low and line held low 20 cycles -> one o_frame_err pulse, o_data/o_sum unchanged; no start detected until line returns high; next good 0x01 accepted normally.
- After one byte, hold line high -> o_done rises exactly idle_bits*3 = 48 cycles after FSM returns to IDLE; next start bit drops o_done the cycle FSM leaves IDLE. With no bytes ever received, o_done stays 0.
- Assert rst at data bit 4 of a frame, release while line high -> all outputs at reset values, no strobe; following 0xA5 frame received correctly with o_sum = 0x000000A5.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a running byte checksum and an idle-done flag.
// The line is synchronized through two flops, then an FSM times each bit from
// the start-bit edge and samples near the middle of every bit period.
module uart_rx #(
    parameter int cycles_per_bit = 3,
    parameter int idle_bits      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_serial,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_frame_err,
    output logic        o_done,
    output logic [31:0] o_sum
);

    localparam int CW       = $clog2(cycles_per_bit + 1);
    localparam int IDLE_TGT = idle_bits * cycles_per_bit;
    localparam int IW       = $clog2(IDLE_TGT + 1);

    localparam logic [CW-1:0] CPB      = CW'(cycles_per_bit);
    localparam logic [CW-1:0] HALF     = CW'(cycles_per_bit / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TGT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic            sync1;
    logic            sync2;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            byte_seen;
    logic [IW-1:0]   idle_cnt;

    // Idle counter saturates so o_done stays high for arbitrarily long quiet periods.
    function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] v);
        return (v >= IDLE_MAX) ? IDLE_MAX : v + 1'b1;
    endfunction

    // Checksum wraps modulo 2^32; the byte is zero-extended.
    function automatic logic [31:0] sum_add(input logic [31:0] s, input logic [7:0] b);
        return s + {24'd0, b};
    endfunction

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= i_serial;
            sync2 <= sync1;
        end
    end

    // Receive FSM: bit timing, sampling, and the registered result strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_sum       <= '0;
            byte_seen   <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!sync2) begin
                        state   <= S_START;
                        bit_cnt <= HALF;
                    end
                end
                S_START: begin
                    if (bit_cnt == CNT_LAST) begin
                        // A start bit that is no longer low at mid-bit was a glitch.
                        if (!sync2) begin
                            state   <= S_DATA;
                            bit_cnt <= CPB;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        shift   <= {sync2, shift[7:1]};
                        bit_cnt <= CPB;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt == CNT_LAST) begin
                        if (sync2) begin
                            o_data    <= shift;
                            o_valid   <= 1'b1;
                            o_sum     <= sum_add(o_sum, shift);
                            byte_seen <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before a new start is armed.
                    if (sync2) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Quiet-line detector: counts idle-high cycles once any byte has been accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            o_done   <= 1'b0;
        end else if (state == S_IDLE && sync2 && byte_seen) begin
            idle_cnt <= sat_inc(idle_cnt);
            o_done   <= (idle_cnt >= IDLE_MAX - 1'b1);
        end else begin
            idle_cnt <= '0;
            o_done   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with cycles_per_bit = 3, idle_bits = 16.
module tb_uart_rx;

    localparam int CPB = 3;
    localparam int IDB = 16;

    logic        clk;
    logic        rst;
    logic        i_serial;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_frame_err;
    logic        o_done;
    logic [31:0] o_sum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = 0;

    // Strobe monitor (written only here).
    int n_valid = 0;
    int n_ferr = 0;
    int n_both = 0;
    int last_v = 0;
    int prev_v = 0;
    int last_f = 0;

    uart_rx #(.cycles_per_bit(CPB), .idle_bits(IDB)) dut (
        .clk(clk),
        .rst(rst),
        .i_serial(i_serial),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_frame_err(o_frame_err),
        .o_done(o_done),
        .o_sum(o_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) begin
            n_valid = n_valid + 1;
            prev_v  = last_v;
            last_v  = cyc;
        end
        if (o_frame_err) begin
            n_ferr = n_ferr + 1;
            last_f = cyc;
        end
        if (o_valid && o_frame_err) n_both = n_both + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Drives one 8N1 frame starting at a negedge; returns after the stop bit period.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        i_serial = 1'b0;
        fall_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            i_serial = b[k];
            repeat (CPB) @(negedge clk);
        end
        i_serial = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        i_serial = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_serial = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", o_data); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", o_frame_err); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
        checks++; if (o_sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %h want 0", o_sum); end
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_without_bytes got %b want 0", o_done); end
    endtask

    task automatic test_single();
        int v0;
        v0 = n_valid;
        send_frame(8'h48, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL single_count got %0d want 1", n_valid - v0); end
        checks++; if (last_v - fall_cyc !== 31) begin errors++; $display("FAIL single_latency got %0d want 31", last_v - fall_cyc); end
        checks++; if (o_data !== 8'h48) begin errors++; $display("FAIL single_data got %h want 48", o_data); end
        checks++; if (o_sum !== 32'h48) begin errors++; $display("FAIL single_sum got %h want 00000048", o_sum); end
        checks++; if (n_ferr !== 0) begin errors++; $display("FAIL single_ferr got %0d want 0", n_ferr); end
    endtask

    task automatic test_done();
        int v;
        int m;
        v = last_v;
        while (cyc < v + 47) @(negedge clk);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_early got %b want 0", o_done); end
        @(negedge clk);
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL done_rise got %b want 1", o_done); end
        m = cyc;
        fork
            send_frame(8'h01, 1'b1);
            begin
                repeat (2) @(negedge clk);
                checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL done_hold got %b want 1 at %0d", o_done, cyc - m); end
                @(negedge clk);
                checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_clear got %b want 0 at %0d", o_done, cyc - m); end
            end
        join
        repeat (5) @(negedge clk);
        checks++; if (o_sum !== 32'h49) begin errors++; $display("FAIL done_sum got %h want 00000049", o_sum); end
    endtask

    task automatic test_back_to_back();
        int v0;
        apply_reset();
        v0 = n_valid;
        send_frame(8'h48, 1'b1);
        send_frame(8'h69, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", n_valid - v0); end
        checks++; if (last_v - prev_v !== 30) begin errors++; $display("FAIL b2b_spacing got %0d want 30", last_v - prev_v); end
        checks++; if (o_data !== 8'h69) begin errors++; $display("FAIL b2b_data got %h want 69", o_data); end
        checks++; if (o_sum !== 32'hB1) begin errors++; $display("FAIL b2b_sum got %h want 000000b1", o_sum); end
        checks++; if (n_ferr !== 0) begin errors++; $display("FAIL b2b_ferr got %0d want 0", n_ferr); end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = n_valid;
        i_serial = 1'b0;
        @(negedge clk);
        i_serial = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", n_valid - v0); end
        checks++; if (n_ferr !== 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", n_ferr); end
        checks++; if (o_sum !== 32'hB1) begin errors++; $display("FAIL glitch_sum got %h want 000000b1", o_sum); end
        send_frame(8'h3C, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL glitch_recover_count got %0d want 1", n_valid - v0); end
        checks++; if (o_data !== 8'h3C) begin errors++; $display("FAIL glitch_recover_data got %h want 3c", o_data); end
        checks++; if (o_sum !== 32'hED) begin errors++; $display("FAIL glitch_recover_sum got %h want 000000ed", o_sum); end
    endtask

    task automatic test_frame_err();
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", n_ferr - f0); end
        checks++; if (last_f - fall_cyc !== 31) begin errors++; $display("FAIL ferr_latency got %0d want 31", last_f - fall_cyc); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", n_valid - v0); end
        checks++; if (o_data !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h want 3c", o_data); end
        checks++; if (o_sum !== 32'hED) begin errors++; $display("FAIL ferr_sum got %h want 000000ed", o_sum); end
        i_serial = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h01, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_after_count got %0d want 1", n_ferr - f0); end
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL ferr_next_count got %0d want 1", n_valid - v0); end
        checks++; if (o_data !== 8'h01) begin errors++; $display("FAIL ferr_next_data got %h want 01", o_data); end
        checks++; if (o_sum !== 32'hEE) begin errors++; $display("FAIL ferr_next_sum got %h want 000000ee", o_sum); end
    endtask

    task automatic test_reset_mid();
        int v0;
        int f0;
        logic [7:0] b;
        b = 8'h5A;
        v0 = n_valid;
        f0 = n_ferr;
        i_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            i_serial = b[k];
            repeat (CPB) @(negedge clk);
        end
        i_serial = b[4];
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        i_serial = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", o_data); end
        checks++; if (o_sum !== 32'h0) begin errors++; $display("FAIL rstmid_sum got %h want 0", o_sum); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", o_done); end
        repeat (40) @(negedge clk);
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL rstmid_valid got %0d want 0", n_valid - v0); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL rstmid_ferr got %0d want 0", n_ferr - f0); end
        send_frame(8'hA5, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL rstmid_next_count got %0d want 1", n_valid - v0); end
        checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL rstmid_next_data got %h want a5", o_data); end
        checks++; if (o_sum !== 32'hA5) begin errors++; $display("FAIL rstmid_next_sum got %h want 000000a5", o_sum); end
        checks++; if (n_both !== 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", n_both); end
    endtask

    initial begin
        rst = 1'b1;
        i_serial = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_done();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
